// File: rtl/bcp_pkg.sv
// Shared types for the BCP scheduler and its processing element.
package bcp_pkg;
  localparam int LIT_INDEX_MAX = 15;
  localparam int CLA_LENGTH    = 3;
  localparam int NUM_CLAUSES   = 8;
  localparam int IQ_DEPTH      = 4;
  localparam int LIT_W         = $clog2(LIT_INDEX_MAX) + 1;
  localparam int CIDX_W        = $clog2(NUM_CLAUSES);

  // Signed literal: sign is polarity, magnitude is variable index, 0 is an empty slot.
  typedef logic signed [LIT_W-1:0] lit_t;
  typedef lit_t [CLA_LENGTH-1:0]   clause_t;

  typedef enum logic [1:0] {IDLE, SCAN, NEXT, RESULT} bcp_state_e;
endpackage

// File: rtl/bcp_sched_if.sv
// Decision, configuration, PE and result signals of the BCP scheduler.
interface bcp_sched_if;
  import bcp_pkg::*;

  logic              cfg_we;
  logic [CIDX_W-1:0] cfg_addr;
  clause_t           cfg_clause;
  logic              dec_valid;
  logic              dec_ready;
  lit_t              dec_lit;
  lit_t              pe_lit;
  clause_t           pe_clause;
  logic              pe_imply;
  lit_t              pe_imply_idx;
  clause_t           pe_pr_clause;
  logic              pe_done;
  logic              pe_conflict;
  logic              imp_valid;
  lit_t              imp_lit;
  logic              busy;
  logic              res_valid;
  logic              res_conflict;
  logic              res_overflow;

  modport master (
    output cfg_we, cfg_addr, cfg_clause, dec_valid, dec_lit,
           pe_imply, pe_imply_idx, pe_pr_clause, pe_done, pe_conflict,
    input  dec_ready, pe_lit, pe_clause, imp_valid, imp_lit,
           busy, res_valid, res_conflict, res_overflow
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_clause, dec_valid, dec_lit,
           pe_imply, pe_imply_idx, pe_pr_clause, pe_done, pe_conflict,
    output dec_ready, pe_lit, pe_clause, imp_valid, imp_lit,
           busy, res_valid, res_conflict, res_overflow
  );
endinterface

// File: rtl/bcp_imp_fifo.sv
// Circular FIFO of implied literals; extra pointer bit separates full from empty.
module bcp_imp_fifo
  import bcp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  lit_t din,
  output lit_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);

  lit_t        mem [DEPTH];
  logic [AW:0] wp, rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + ONE;
      if (pop && !empty) rp <= rp + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/bcp_pe.sv
// Combinational BCP element: applies one decided literal to one clause.
module bcp_pe
  import bcp_pkg::*;
(
  input  lit_t    litDec,
  input  clause_t clause,
  output logic    imply,
  output lit_t    imply_idx,
  output clause_t pr_clause,
  output logic    done,
  output logic    conflict
);
  localparam int CW = $clog2(CLA_LENGTH + 1);

  lit_t          neg;
  logic [CW-1:0] live;

  assign neg = -litDec;

  // Falsified literals are cleared; a single survivor is the implied literal.
  always_comb begin
    pr_clause = clause;
    done      = 1'b0;
    imply_idx = '0;
    live      = '0;
    for (int i = 0; i < CLA_LENGTH; i++) begin
      if (clause[i] == litDec) done = 1'b1;
      if (clause[i] == neg) pr_clause[i] = '0;
      if (pr_clause[i] != '0) begin
        live      = live + CW'(1);
        imply_idx = pr_clause[i];
      end
    end
    conflict = !done && (live == '0);
    imply    = !done && (live == CW'(1));
    if (!imply) imply_idx = '0;
  end
endmodule

// File: rtl/bcp_sched.sv
// Streams the clause store through an external bcp_pe, one clause per cycle,
// re-running passes on queued implications until fixpoint, conflict or overflow.
module bcp_sched
  import bcp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  bcp_sched_if.slave bus
);
  localparam logic [CIDX_W-1:0] LAST = CIDX_W'(NUM_CLAUSES - 1);

  bcp_state_e             state, state_nxt;
  clause_t                store [NUM_CLAUSES];
  logic [NUM_CLAUSES-1:0] sat;
  logic [CIDX_W-1:0]      cidx;
  lit_t                   cur_lit, q_dout;
  logic                   q_push, q_pop, q_flush, q_full, q_empty;
  logic                   wr_pr, set_sat, set_conf, set_ovf;
  logic                   conf_q, ovf_q, cfg_ok, live;

  assign cfg_ok = bus.cfg_we && (state == IDLE);
  assign live   = (state == SCAN) && !sat[cidx];

  bcp_imp_fifo #(.DEPTH(IQ_DEPTH)) u_iq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .flush (q_flush),
    .din   (bus.pe_imply_idx),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    state_nxt = state;
    q_push    = 1'b0;
    q_pop     = 1'b0;
    q_flush   = 1'b0;
    wr_pr     = 1'b0;
    set_sat   = 1'b0;
    set_conf  = 1'b0;
    set_ovf   = 1'b0;
    case (state)
      IDLE: if (bus.dec_valid) state_nxt = SCAN;
      SCAN: begin
        // Satisfied clauses are skipped; the PE result is ignored for them.
        if (live) begin
          if (bus.pe_conflict) set_conf = 1'b1;
          else begin
            set_sat = bus.pe_done;
            wr_pr   = !bus.pe_done;
            if (bus.pe_imply) begin
              if (q_full) set_ovf = 1'b1;
              else        q_push  = 1'b1;
            end
          end
        end
        if (set_conf || set_ovf) state_nxt = RESULT;
        else if (cidx == LAST)   state_nxt = NEXT;
      end
      NEXT: begin
        if (q_empty) state_nxt = RESULT;
        else begin
          q_pop     = 1'b1;
          state_nxt = SCAN;
        end
      end
      RESULT: begin
        q_flush   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cidx    <= '0;
      cur_lit <= '0;
      sat     <= '0;
      conf_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.dec_valid) begin
          cur_lit <= bus.dec_lit;
          cidx    <= '0;
          conf_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end
        SCAN: cidx <= cidx + CIDX_W'(1);
        NEXT: if (q_pop) begin
          cur_lit <= q_dout;
          cidx    <= '0;
        end
        default: ;
      endcase
      if (cfg_ok)   sat[bus.cfg_addr] <= 1'b0;
      if (set_sat)  sat[cidx]         <= 1'b1;
      if (set_conf) conf_q            <= 1'b1;
      if (set_ovf)  ovf_q             <= 1'b1;
    end
  end

  // Store is not reset; the host reloads it after an aborted pass.
  always_ff @(posedge clk) begin
    if (cfg_ok)     store[bus.cfg_addr] <= bus.cfg_clause;
    else if (wr_pr) store[cidx]         <= bus.pe_pr_clause;
  end

  assign bus.dec_ready    = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.pe_lit       = (state == SCAN) ? cur_lit : '0;
  assign bus.pe_clause    = (state == SCAN) ? store[cidx] : '0;
  assign bus.imp_valid    = q_push;
  assign bus.imp_lit      = q_push ? bus.pe_imply_idx : '0;
  assign bus.res_valid    = (state == RESULT);
  assign bus.res_conflict = (state == RESULT) && conf_q;
  assign bus.res_overflow = (state == RESULT) && ovf_q;
endmodule

// File: tb/tb_bcp_sched.sv
// Bench for bcp_sched with a real bcp_pe: directed table, corner sequences, random vs queue model.
module tb_bcp_sched;
  import bcp_pkg::*;

  localparam int N      = NUM_CLAUSES;
  localparam int BUDGET = 2000;

  typedef struct {
    int kind; int dec; int lat; int conf; int ovf; int nimp; int imp0; int imp1;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   imps[$];
  int   m_imps[$];
  int   m_store [N][CLA_LENGTH];
  bit   m_sat [N];
  vec_t tbl [7];

  always #5 clk = ~clk;

  bcp_sched_if bus();

  bcp_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bcp_pe u_pe (
    .litDec    (bus.pe_lit),
    .clause    (bus.pe_clause),
    .imply     (bus.pe_imply),
    .imply_idx (bus.pe_imply_idx),
    .pr_clause (bus.pe_pr_clause),
    .done      (bus.pe_done),
    .conflict  (bus.pe_conflict)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic wr(input int a, input int x0, input int x1, input int x2);
    clause_t cc;
    cc[0] = lit_t'(x0);
    cc[1] = lit_t'(x1);
    cc[2] = lit_t'(x2);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = CIDX_W'(a);
    bus.cfg_clause = cc;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    m_store[a][0] = x0;
    m_store[a][1] = x1;
    m_store[a][2] = x2;
    m_sat[a] = 1'b0;
  endtask

  // kind 0: keep store; 1: (1,2,0)x8; 2: chain; 3: conflict; 4: overflow; 5: (4,5,6)x8
  task automatic load(input int kind);
    if (kind != 0)
      for (int a = 0; a < N; a++) begin
        if (kind == 1)               wr(a, 1, 2, 0);
        else if (kind == 2 && a < 2) wr(a, (a == 0) ? -1 : -2, a + 2, 0);
        else if (kind == 3 && a < 2) wr(a, -1, (a == 0) ? 2 : -2, 0);
        else if (kind == 4 && a < 5) wr(a, -1, a + 2, 0);
        else                         wr(a, 4, 5, 6);
      end
  endtask

  // Called at a negedge in IDLE; lat counts cycles from accept to res_valid.
  task automatic run(input int d, output int lat, output int rc, output int ro);
    bit seen;
    seen = 1'b0;
    lat = -1; rc = 0; ro = 0;
    imps.delete();
    bus.dec_valid = 1'b1;
    bus.dec_lit   = lit_t'(d);
    for (int c = 1; c <= BUDGET && !seen; c++) begin
      @(negedge clk);
      bus.dec_valid = 1'b0;
      if (c == 1) chk("busy_after_accept", int'(bus.busy), 1);
      if (bus.imp_valid) imps.push_back(int'(bus.imp_lit));
      if (bus.res_valid) begin
        lat  = c;
        rc   = int'(bus.res_conflict);
        ro   = int'(bus.res_overflow);
        seen = 1'b1;
      end
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL res_timeout: no res_valid within %0d cycles", BUDGET);
    end
    @(negedge clk);
    chk("res_single_pulse", int'(bus.res_valid), 0);
    chk("ready_after_res", int'(bus.dec_ready), 1);
  endtask

  task automatic wait_res();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < BUDGET && !seen; c++) begin
      @(negedge clk);
      seen = bus.res_valid;
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL wait_res: no res_valid within %0d cycles", BUDGET);
    end
    @(negedge clk);
  endtask

  // Whole-pass model: sat set, FIFO of implications, pass counting for latency.
  task automatic model(input int d, output int lat, output int rc, output int ro);
    int q[$];
    int cur, passes;
    bit stop;
    cur = d; passes = 0; stop = 1'b0;
    lat = -1; rc = 0; ro = 0;
    m_imps.delete();
    while (!stop && passes < 300) begin
      for (int i = 0; i < N && !stop; i++) begin
        if (!m_sat[i]) begin
          int pr [CLA_LENGTH];
          int nlive, unit;
          bit hit;
          hit = 1'b0; nlive = 0; unit = 0;
          foreach (pr[j]) begin
            pr[j] = (m_store[i][j] == -cur) ? 0 : m_store[i][j];
            if (m_store[i][j] == cur) hit = 1'b1;
            if (pr[j] != 0) begin nlive++; unit = pr[j]; end
          end
          if (hit) m_sat[i] = 1'b1;
          else if (nlive == 0) begin
            rc = 1; lat = passes * (N + 1) + i + 2; stop = 1'b1;
          end else begin
            m_store[i] = pr;
            if (nlive == 1) begin
              if (q.size() == IQ_DEPTH) begin
                ro = 1; lat = passes * (N + 1) + i + 2; stop = 1'b1;
              end else begin
                q.push_back(unit);
                m_imps.push_back(unit);
              end
            end
          end
        end
      end
      if (!stop) begin
        passes++;
        if (q.size() == 0) begin lat = passes * (N + 1) + 1; stop = 1'b1; end
        else cur = q.pop_front();
      end
    end
  endtask

  function automatic int rlit();
    int v;
    if ($urandom_range(0, 3) == 0) return 0;
    v = int'($urandom_range(1, 5));
    return ($urandom_range(0, 1) == 1) ? v : -v;
  endfunction

  initial begin
    int cnt, lat, rc, ro;
    tbl[0] = '{1,  1, 10, 0, 0, 0, 0,  0};
    tbl[1] = '{2,  1, 28, 0, 0, 2, 2,  3};
    tbl[2] = '{0, -2, 10, 0, 0, 0, 0,  0};
    tbl[3] = '{3,  1, 12, 1, 0, 2, 2, -2};
    tbl[4] = '{1,  1, 10, 0, 0, 0, 0,  0};
    tbl[5] = '{4,  1,  6, 0, 1, 4, 2,  3};
    tbl[6] = '{1,  1, 10, 0, 0, 0, 0,  0};

    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_clause = '0;
    bus.dec_valid  = 1'b1;
    bus.dec_lit    = lit_t'(1);

    // Reset held with a decision pending.
    @(negedge clk);
    chk("rst_dec_ready", int'(bus.dec_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_imp_valid", int'(bus.imp_valid), 0);
    chk("rst_pe_lit", int'(bus.pe_lit), 0);
    load(1);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("first_accept_busy", int'(bus.busy), 1);
        bus.dec_valid = 1'b0;
      end
      if (bus.res_valid) cnt++;
    end
    chk("first_dec_res_count", cnt, 1);

    // Directed table.
    foreach (tbl[r]) begin
      load(tbl[r].kind);
      run(tbl[r].dec, lat, rc, ro);
      chk("tbl_lat", lat, tbl[r].lat);
      chk("tbl_conflict", rc, tbl[r].conf);
      chk("tbl_overflow", ro, tbl[r].ovf);
      chk("tbl_nimp", imps.size(), tbl[r].nimp);
      if (tbl[r].nimp > 0 && imps.size() > 0) chk("tbl_imp0", imps[0], tbl[r].imp0);
      if (tbl[r].nimp > 1 && imps.size() > 1) chk("tbl_imp1", imps[1], tbl[r].imp1);
    end

    // cfg_we during SCAN: an empty clause at 7 would conflict if it landed.
    load(5);
    bus.dec_valid = 1'b1;
    bus.dec_lit   = lit_t'(1);
    @(negedge clk);
    bus.dec_valid  = 1'b0;
    chk("dec_ready_in_scan", int'(bus.dec_ready), 0);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = CIDX_W'(7);
    bus.cfg_clause = '0;
    repeat (3) @(negedge clk);
    bus.cfg_we = 1'b0;
    wait_res();
    run(1, lat, rc, ro);
    chk("cfg_in_scan_lat", lat, 10);
    chk("cfg_in_scan_conflict", rc, 0);

    // Reset mid-SCAN aborts with no result.
    load(5);
    bus.dec_valid = 1'b1;
    bus.dec_lit   = lit_t'(1);
    @(negedge clk);
    bus.dec_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_dec_ready", int'(bus.dec_ready), 1);
    @(negedge clk);
    chk("midrst_res_valid", int'(bus.res_valid), 0);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.res_valid) cnt++;
    end
    chk("midrst_no_result", cnt, 0);

    // Random stores and decisions against the model; store state persists when not reloaded.
    for (int it = 0; it < 40; it++) begin
      int d, lm, rcm, rom;
      if (it == 0 || $urandom_range(0, 3) != 0)
        for (int a = 0; a < N; a++) wr(a, rlit(), rlit(), rlit());
      d = int'($urandom_range(1, 5));
      if ($urandom_range(0, 1) == 1) d = -d;
      model(d, lm, rcm, rom);
      run(d, lat, rc, ro);
      chk("rnd_lat", lat, lm);
      chk("rnd_conflict", rc, rcm);
      chk("rnd_overflow", ro, rom);
      chk("rnd_nimp", imps.size(), m_imps.size());
      for (int k = 0; k < imps.size() && k < m_imps.size(); k++)
        chk("rnd_imp", imps[k], m_imps[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
